// File: rtl/local_pht_scheduler.sv
// Local pattern-history table port scheduler: init sweep, then arbitrates one table
// access per cycle between prediction lookups and buffered read-modify-write updates.
module local_pht_scheduler #(
  parameter int IDX_W     = 10,
  parameter int CTR_W     = 3,
  parameter int UPD_DEPTH = 4,
  parameter int INIT_VAL  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             init_done,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [CTR_W-1:0] tbl_wdata,
  input  logic [CTR_W-1:0] tbl_rdata
);
  localparam int PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CNT_W = $clog2(UPD_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(UPD_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(UPD_DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_ptr;
  logic [IDX_W-1:0] fifo_idx [UPD_DEPTH];
  logic             fifo_tkn [UPD_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_phase;
  logic [IDX_W-1:0] rmw_idx_p1;
  logic             rmw_taken_p1;
  logic             vld_p1;

  logic             fifo_full, fifo_empty, push, pop, lk_acc;
  logic             en_c, we_c;
  logic [IDX_W-1:0] addr_c;
  logic [CTR_W-1:0] wdata_c;

  function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_MAX) ? ctr : ctr + CTR_W'(1);
    return (ctr == '0) ? ctr : ctr - CTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign upd_ready  = !fifo_full;
  assign push       = upd_valid && !fifo_full;
  assign init_done  = (state == S_RUN);

  // Stage p0: port arbitration; a pending write-back always wins so RMWs never overlap
  always_comb begin
    state_nxt    = state;
    en_c         = 1'b0;
    we_c         = 1'b0;
    addr_c       = '0;
    wdata_c      = '0;
    pop          = 1'b0;
    lk_acc       = 1'b0;
    lookup_ready = 1'b0;
    case (state)
      S_INIT: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = sweep_ptr;
        wdata_c = CTR_W'(INIT_VAL);
        if (sweep_ptr == LAST_IDX) state_nxt = S_RUN;
      end
      S_RUN: begin
        lookup_ready = !wr_phase && !fifo_full;
        if (wr_phase) begin
          en_c    = 1'b1;
          we_c    = 1'b1;
          addr_c  = rmw_idx_p1;
          wdata_c = sat_step(tbl_rdata, rmw_taken_p1);
        end else if (fifo_full) begin
          en_c   = 1'b1;
          addr_c = fifo_idx[rd_ptr];
          pop    = 1'b1;
        end else if (lookup_valid) begin
          en_c   = 1'b1;
          addr_c = lookup_idx;
          lk_acc = 1'b1;
        end else if (!fifo_empty) begin
          en_c   = 1'b1;
          addr_c = fifo_idx[rd_ptr];
          pop    = 1'b1;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // The port must stay quiet for the whole reset assertion, not just after the edge
  assign tbl_en    = en_c && !reset;
  assign tbl_we    = we_c && !reset;
  assign tbl_addr  = addr_c;
  assign tbl_wdata = wdata_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      sweep_ptr <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_phase  <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) sweep_ptr <= sweep_ptr + IDX_W'(1);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      wr_phase <= pop;
      vld_p1   <= lk_acc;
    end
  end

  // Stage p1: latched update operands and lookup result
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_idx[wr_ptr] <= upd_idx;
      fifo_tkn[wr_ptr] <= upd_taken;
    end
    if (pop) begin
      rmw_idx_p1   <= fifo_idx[rd_ptr];
      rmw_taken_p1 <= fifo_tkn[rd_ptr];
    end
  end

  assign pred_valid = vld_p1;
  assign pred_taken = vld_p1 && tbl_rdata[CTR_W-1];

endmodule

// File: tb/tb_local_pht_scheduler.sv
// Directed bench for local_pht_scheduler with a behavioural table RAM and a
// prediction scoreboard checked by an independent monitor.
module tb_local_pht_scheduler;
  localparam int IDX_W = 10;
  localparam int CTR_W = 3;
  localparam int NENT  = 1 << IDX_W;

  logic             clock = 1'b0;
  logic             reset;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             init_done;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [CTR_W-1:0] tbl_wdata;
  logic [CTR_W-1:0] tbl_rdata;

  logic [CTR_W-1:0] mem [NENT];
  logic             exp_q [$];
  int               n_checks = 0;
  int               n_errors = 0;

  local_pht_scheduler #(.IDX_W(IDX_W), .CTR_W(CTR_W), .UPD_DEPTH(4), .INIT_VAL(3)) dut (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .init_done(init_done),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_op(input string name, input logic en, input logic we,
                          input logic [IDX_W-1:0] a, input logic [CTR_W-1:0] d);
    logic [CTR_W-1:0] wd;
    wd = tbl_we ? tbl_wdata : '0;
    check(name, 32'({tbl_en, tbl_we, tbl_addr, wd}), 32'({en, we, a, we ? d : 3'd0}));
  endtask

  // Scoreboard monitor
  initial begin
    logic e;
    forever begin
      @(negedge clock);
      if (pred_valid) begin
        if (exp_q.size() == 0) check("pred_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pred_taken", 32'(pred_taken), 32'(e));
        end
      end
    end
  end

  task automatic sweep_check();
    int bad;
    bad = 0;
    for (int i = 0; i < NENT; i++) begin
      @(negedge clock);
      if (i == 0) check_op("sweep_first", 1'b1, 1'b1, '0, 3'd3);
      if (!(tbl_en && tbl_we && tbl_addr == IDX_W'(i) && tbl_wdata == 3'd3 &&
            !init_done && !lookup_ready)) bad++;
    end
    check("sweep_bad_cycles", 32'(bad), 0);
    @(negedge clock);
    check("init_done_after_sweep", 32'(init_done), 1);
    check("idle_after_sweep", 32'(tbl_en), 0);
  endtask

  task automatic do_lookup(input logic [IDX_W-1:0] idx, input logic exp);
    lookup_valid = 1'b1;
    lookup_idx   = idx;
    check("lookup_ready_idle", 32'(lookup_ready), 1);
    exp_q.push_back(exp);
    @(negedge clock);
    lookup_valid = 1'b0;
  endtask

  task automatic do_update(input logic [IDX_W-1:0] idx, input logic tkn);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = tkn;
    @(negedge clock);
    upd_valid = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int busy;
    reset = 1'b1; lookup_valid = 1'b0; lookup_idx = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pred_valid", 32'(pred_valid), 0);
    check("rst_pred_taken", 32'(pred_taken), 0);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_tbl_en", 32'(tbl_en), 0);
    check("rst_tbl_we", 32'(tbl_we), 0);
    check("rst_upd_ready", 32'(upd_ready), 1);
    check("rst_lookup_ready", 32'(lookup_ready), 0);
    @(posedge clock); #1 reset = 1'b0;
    sweep_check();

    do_lookup(10'd5, 1'b0);
    // Saturating counter walk on entry 5
    do_update(10'd5, 1'b1);
    check("ctr5_after_1_taken", 32'(mem[5]), 4);
    do_lookup(10'd5, 1'b1);
    repeat (5) do_update(10'd5, 1'b1);
    check("ctr5_sat_high", 32'(mem[5]), 7);
    do_lookup(10'd5, 1'b1);
    repeat (8) do_update(10'd5, 1'b0);
    check("ctr5_sat_low", 32'(mem[5]), 0);
    do_lookup(10'd5, 1'b0);

    // Back-to-back same-index updates
    upd_valid = 1'b1; upd_idx = 10'd9; upd_taken = 1'b1;
    check("b2b_upd_ready", 32'(upd_ready), 1);
    @(negedge clock);
    check_op("b2b_read1", 1'b1, 1'b0, 10'd9, 3'd0);
    @(negedge clock);
    upd_valid = 1'b0;
    check_op("b2b_write1", 1'b1, 1'b1, 10'd9, 3'd4);
    @(negedge clock);
    check_op("b2b_read2", 1'b1, 1'b0, 10'd9, 3'd0);
    @(negedge clock);
    check_op("b2b_write2", 1'b1, 1'b1, 10'd9, 3'd5);
    @(negedge clock);
    check("b2b_idle", 32'(tbl_en), 0);
    check("ctr9_final", 32'(mem[9]), 5);
    do_lookup(10'd9, 1'b1);

    // Continuous lookups versus a filling update FIFO
    lookup_valid = 1'b1; lookup_idx = 10'd20;
    upd_valid = 1'b1; upd_idx = 10'd30; upd_taken = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("starve_lookup_ready", 32'(lookup_ready), 1);
      check("starve_upd_ready", 32'(upd_ready), 1);
      exp_q.push_back(1'b0);
      @(negedge clock);
    end
    upd_valid = 1'b0;
    check("full_upd_ready", 32'(upd_ready), 0);
    check("full_lookup_ready", 32'(lookup_ready), 0);
    check_op("full_forced_read", 1'b1, 1'b0, 10'd30, 3'd0);
    @(negedge clock);
    check("wrphase_lookup_ready", 32'(lookup_ready), 0);
    check_op("full_forced_write", 1'b1, 1'b1, 10'd30, 3'd4);
    lookup_valid = 1'b0;
    repeat (8) @(negedge clock);
    check("ctr30_drained", 32'(mem[30]), 7);
    check("drain_idle", 32'(tbl_en), 0);

    // Async reset landing on a write-phase cycle
    upd_valid = 1'b1; upd_idx = 10'd40; upd_taken = 1'b1;
    @(negedge clock);
    upd_idx = 10'd41; upd_taken = 1'b0;
    check_op("rst_test_read", 1'b1, 1'b0, 10'd40, 3'd0);
    @(negedge clock);
    upd_valid = 1'b0;
    check_op("rst_test_write", 1'b1, 1'b1, 10'd40, 3'd4);
    #1 reset = 1'b1;
    #1;
    check("arst_tbl_en", 32'(tbl_en), 0);
    check("arst_tbl_we", 32'(tbl_we), 0);
    check("arst_init_done", 32'(init_done), 0);
    check("arst_lookup_ready", 32'(lookup_ready), 0);
    check("arst_upd_ready", 32'(upd_ready), 1);
    @(posedge clock);
    @(negedge clock);
    check("arst_ctr40_unchanged", 32'(mem[40]), 3);
    @(posedge clock); #1 reset = 1'b0;
    sweep_check();
    busy = 0;
    repeat (6) begin
      @(negedge clock);
      if (tbl_en) busy++;
    end
    check("fifo_flushed_idle", 32'(busy), 0);
    check("ctr41_after_flush", 32'(mem[41]), 3);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
